// File: rtl/bus_src_fifo_if.sv
// Device-to-arbiter source FIFO bus bundle.
// master drives writes/pops, slave is the FIFO.
interface bus_src_fifo_if #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
);
  localparam int cw = $clog2(depth + 1);

  logic               wr;
  logic [pckg_sz-1:0] D_in;
  logic               full;
  logic               pndng;
  logic               pop;
  logic [pckg_sz-1:0] D_pop;
  logic [cw-1:0]      count;
  logic               ovf;
  logic               udf;
  logic               clr_err;

  modport master (
    output wr, D_in, pop, clr_err,
    input  full, pndng, D_pop, count, ovf, udf
  );

  modport slave (
    input  wr, D_in, pop, clr_err,
    output full, pndng, D_pop, count, ovf, udf
  );
endinterface

// File: rtl/bus_src_fifo.sv
// Fall-through circular FIFO feeding one bus arbiter port.
// Sticky overflow/underflow flags, any depth 2..256.
module bus_src_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input logic           clk,
  input logic           reset,
  bus_src_fifo_if.slave bus
);
  localparam int pw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth + 1);

  logic [pckg_sz-1:0] mem [depth];
  logic [pw-1:0]      wp;
  logic [pw-1:0]      rp;
  logic [cw-1:0]      cnt;
  logic               ovf_q;
  logic               udf_q;
  logic               full_w;
  logic               pndng_w;
  logic               wr_ok;
  logic               rd_ok;
  logic               ovf_ev;
  logic               udf_ev;

  function automatic logic [pw-1:0] nxt(
    input logic [pw-1:0] p
  );
    return (p == pw'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_w  = (cnt == cw'(depth));
  assign pndng_w = (cnt != '0);
  assign wr_ok   = bus.wr && (!full_w || bus.pop);
  assign rd_ok   = bus.pop && pndng_w;
  assign ovf_ev  = bus.wr && full_w && !bus.pop;
  assign udf_ev  = bus.pop && !pndng_w;

  assign bus.full  = full_w;
  assign bus.pndng = pndng_w;
  assign bus.count = cnt;
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;
  assign bus.D_pop = mem[rp];

  // Storage array; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem[wp] <= bus.D_in;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= nxt(wp);
      if (rd_ok) rp <= nxt(rp);
      unique case (1'b1)
        wr_ok && !rd_ok: cnt <= cnt + 1'b1;
        rd_ok && !wr_ok: cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky error flags; a new event beats clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_ev || (ovf_q && !bus.clr_err);
      udf_q <= udf_ev || (udf_q && !bus.clr_err);
    end
  end
endmodule

// File: tb/tb_bus_src_fifo.sv
// Directed bench for bus_src_fifo.
// Depth 8 vector table plus depth 5 wrap/reset sequence.
module tb_bus_src_fifo;
  logic clk;
  logic rst8;
  logic rst5;

  bus_src_fifo_if #(.pckg_sz(16), .depth(8)) b8 ();
  bus_src_fifo_if #(.pckg_sz(16), .depth(5)) b5 ();

  bus_src_fifo #(.pckg_sz(16), .depth(8)) u8 (
    .clk   (clk),
    .reset (rst8),
    .bus   (b8.slave)
  );

  bus_src_fifo #(.pckg_sz(16), .depth(5)) u5 (
    .clk   (clk),
    .reset (rst5),
    .bus   (b5.slave)
  );

  typedef struct {
    logic        wr;
    logic [15:0] din;
    logic        pop;
    logic        clr;
    logic [3:0]  cnt;
    logic        pnd;
    logic        ful;
    logic [15:0] dpop;
    logic        ov;
    logic        ud;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] q[$];
  int          tests;
  int          failed;

  always #5 clk = ~clk;

  function automatic void add(
    input logic wr, input logic [15:0] din,
    input logic pop, input logic clr,
    input int cnt, input logic pnd, input logic ful,
    input logic [15:0] dpop,
    input logic ov, input logic ud
  );
    vec_t v;
    v.wr = wr; v.din = din; v.pop = pop; v.clr = clr;
    v.cnt = 4'(cnt); v.pnd = pnd; v.ful = ful;
    v.dpop = dpop; v.ov = ov; v.ud = ud;
    tbl.push_back(v);
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    clk = 0;
    rst8 = 0;
    rst5 = 0;
    b8.wr = 0; b8.D_in = '0; b8.pop = 0; b8.clr_err = 0;
    b5.wr = 0; b5.D_in = '0; b5.pop = 0; b5.clr_err = 0;

    add(1, 16'h1234, 0, 0, 1, 1, 0, 16'h1234, 0, 0);
    add(1, 16'h5678, 0, 0, 2, 1, 0, 16'h1234, 0, 0);
    add(0, 16'h0000, 1, 0, 1, 1, 0, 16'h5678, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    for (int k = 0; k < 8; k++)
      add(1, 16'(k), 0, 0, k + 1, 1, k == 7, 16'h0000, 0, 0);
    add(1, 16'hFFFF, 0, 0, 8, 1, 1, 16'h0000, 1, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 16'h0000, 1, 0, 8 - k, k < 8, 0, 16'(k), 1, 0);
    add(0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000, 0, 0);
    for (int k = 0; k < 8; k++)
      add(1, 16'h0010 + 16'(k), 0, 0, k + 1, 1, k == 7,
          16'h0010, 0, 0);
    add(1, 16'hAAAA, 1, 0, 8, 1, 1, 16'h0011, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 16'h0000, 1, 0, 8 - k, k < 8, 0,
          (k < 7) ? 16'h0011 + 16'(k) : 16'hAAAA, 0, 0);
    add(1, 16'h00BB, 1, 0, 1, 1, 0, 16'h00BB, 0, 1);
    add(0, 16'h0000, 0, 1, 1, 1, 0, 16'h00BB, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 1);
    add(0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0, 1);
    add(0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000, 0, 0);

    #2;
    chk("rst_count", 32'(b8.count), 0);
    chk("rst_pndng", 32'(b8.pndng), 0);
    chk("rst_full", 32'(b8.full), 0);
    chk("rst_ovf", 32'(b8.ovf), 0);
    chk("rst_udf", 32'(b8.udf), 0);
    #10;
    rst8 = 1;
    rst5 = 1;

    foreach (tbl[i]) begin
      b8.wr = tbl[i].wr;
      b8.D_in = tbl[i].din;
      b8.pop = tbl[i].pop;
      b8.clr_err = tbl[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), 32'(b8.count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_pndng", i), 32'(b8.pndng), 32'(tbl[i].pnd));
      chk($sformatf("v%0d_full", i), 32'(b8.full), 32'(tbl[i].ful));
      chk($sformatf("v%0d_ovf", i), 32'(b8.ovf), 32'(tbl[i].ov));
      chk($sformatf("v%0d_udf", i), 32'(b8.udf), 32'(tbl[i].ud));
      if (tbl[i].pnd)
        chk($sformatf("v%0d_dpop", i), 32'(b8.D_pop), 32'(tbl[i].dpop));
    end
    b8.wr = 0; b8.pop = 0; b8.clr_err = 0;

    for (int k = 0; k < 3; k++) begin
      b5.wr = 1;
      b5.D_in = 16'hA000 + 16'(k);
      @(posedge clk);
      #1;
      q.push_back(16'hA000 + 16'(k));
    end
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("w%0d_dpop", k), 32'(b5.D_pop), 32'(q[0]));
      b5.wr = 1;
      b5.pop = 1;
      b5.D_in = 16'hA003 + 16'(k);
      @(posedge clk);
      #1;
      void'(q.pop_front());
      q.push_back(16'hA003 + 16'(k));
      chk($sformatf("w%0d_count", k), 32'(b5.count), 3);
    end
    b5.wr = 0;
    b5.pop = 0;
    chk("w_head", 32'(b5.D_pop), 32'(q[0]));
    #2;
    rst5 = 0;
    #1;
    chk("arst_pndng", 32'(b5.pndng), 0);
    chk("arst_count", 32'(b5.count), 0);
    chk("arst_full", 32'(b5.full), 0);
    #1;
    rst5 = 1;
    b5.wr = 1;
    b5.D_in = 16'h0055;
    @(posedge clk);
    #1;
    b5.wr = 0;
    chk("post_rst_count", 32'(b5.count), 1);
    chk("post_rst_dpop", 32'(b5.D_pop), 32'h0055);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
